// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard with control-flush FSM driving decode stall/bubble.
//   Ports: clk/resetn (async active-low); id_* decode instruction fields; mm_load_done/mm_load_rd load data return;
//   retire_valid/retire_rd writeback leave; ex_redirect early flush exit; stall/bubble/issue decode controls.
//   Build option: define HAZARD_FORWARD_EN when a bypass network exists (only load-use hazards stall).
module hazard_scoreboard #(
  parameter int NREGS        = 32,
  parameter int ADDR_W       = $clog2(NREGS),
  parameter int MAX_INFLIGHT = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_is_jump,
  input  logic              mm_load_done,
  input  logic [ADDR_W-1:0] mm_load_rd,
  input  logic              retire_valid,
  input  logic [ADDR_W-1:0] retire_rd,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              bubble,
  output logic              issue
);
  localparam int CW    = $clog2(MAX_INFLIGHT + 1);
  localparam int CNT_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]    MAX_C    = CW'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    pend_q [NREGS];
  logic [CW-1:0]    pend_d [NREGS];
  logic [CW-1:0]    ldpend_q [NREGS];
  logic [CW-1:0]    ldpend_d [NREGS];
  logic             wr, rs1_busy, rs2_busy, haz, underflow;
  function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic inc, input logic dec);
    return (inc && !dec) ? c + 1'b1 : (dec && !inc && c != '0) ? c - 1'b1 : c;
  endfunction
  assign wr = id_rd_we && id_rd != '0;
`ifdef HAZARD_FORWARD_EN
  assign rs1_busy = ldpend_q[id_rs1] != '0;
  assign rs2_busy = ldpend_q[id_rs2] != '0;
`else
  assign rs1_busy = pend_q[id_rs1] != '0;
  assign rs2_busy = pend_q[id_rs2] != '0;
`endif
  // Structural term keeps a counter from ever wrapping past MAX_INFLIGHT.
  assign haz = id_valid && ((id_rs1_used && id_rs1 != '0 && rs1_busy) ||
                            (id_rs2_used && id_rs2 != '0 && rs2_busy) ||
                            (wr && pend_q[id_rd] == MAX_C));
  always_comb begin
    stall  = resetn && state_q == IDLE && haz;
    bubble = resetn && state_q == FLUSH;
    issue  = resetn && state_q == IDLE && id_valid && !haz;
  end
  // Entry 0 is never stepped, so x0 stays permanently clear.
  always_comb begin
    underflow = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r]   = pend_q[r];
      ldpend_d[r] = ldpend_q[r];
      if (r != 0) begin
        pend_d[r]   = step(pend_q[r], issue && wr && id_rd == ADDR_W'(r),
                           retire_valid && retire_rd == ADDR_W'(r));
        ldpend_d[r] = step(ldpend_q[r], issue && wr && id_is_load && id_rd == ADDR_W'(r),
                           mm_load_done && mm_load_rd == ADDR_W'(r));
        underflow   = underflow ||
                      (retire_valid && retire_rd == ADDR_W'(r) && pend_q[r] == '0 &&
                       !(issue && wr && id_rd == ADDR_W'(r))) ||
                      (mm_load_done && mm_load_rd == ADDR_W'(r) && ldpend_q[r] == '0 &&
                       !(issue && wr && id_is_load && id_rd == ADDR_W'(r)));
      end
    end
  end
  // Redirect takes priority over the remaining count.
  always_comb begin
    state_d = state_q == IDLE ? ((issue && id_is_jump) ? FLUSH : IDLE)
                              : ((cnt_q == '0 || ex_redirect) ? IDLE : FLUSH);
    cnt_d   = state_q == IDLE ? ((issue && id_is_jump) ? CNT_INIT : '0)
                              : (state_d == IDLE ? '0 : cnt_q - 1'b1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r]   <= '0;
        ldpend_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r]   <= pend_d[r];
        ldpend_q[r] <= ldpend_d[r];
      end
    end
  end
  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn) !underflow);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall/bubble/issue for the default (no bypass) build.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       resetn;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_jump;
  logic [4:0] id_rs1, id_rs2, id_rd, mm_load_rd, retire_rd;
  logic       mm_load_done, retire_valid, ex_redirect;
  logic       stall, bubble, issue;
  int         n_chk = 0;
  int         n_err = 0;
  hazard_scoreboard dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_jump(id_is_jump), .mm_load_done(mm_load_done),
    .mm_load_rd(mm_load_rd), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .ex_redirect(ex_redirect), .stall(stall), .bubble(bubble), .issue(issue)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: {stall,bubble,issue} got %b want %b", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic ld, input logic jmp);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_is_jump = jmp;
    mm_load_done = 1'b0; mm_load_rd = '0; retire_valid = 1'b0; retire_rd = '0; ex_redirect = 1'b0;
  endtask
  task automatic ret(input logic [4:0] rd);
    retire_valid = 1'b1; retire_rd = rd;
  endtask
  task automatic cyc(input string tag, input logic [2:0] exp);
    #2 chk(tag, {stall, bubble, issue}, exp);
    @(posedge clk); #1;
  endtask
  initial begin
    resetn = 1'b0;
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0);
    #2 chk("reset", {stall, bubble, issue}, 3'b000);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0);          cyc("add_x5", 3'b001);
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0);          cyc("raw_x5", 3'b100);
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0); ret(5);  cyc("raw_same_retire", 3'b100);
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0);          cyc("raw_clear", 3'b001);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); ret(6);  cyc("idle", 3'b000);
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);          cyc("lw_x7", 3'b001);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0);          cyc("load_use", 3'b100);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0); mm_load_done = 1'b1; mm_load_rd = 7;
    cyc("load_done_same", 3'b100);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0);          cyc("wait_retire_x7", 3'b100);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0); ret(7);  cyc("retire_x7_same", 3'b100);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0);          cyc("lw_clear", 3'b001);
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 1, 0, 1, 0, 1, 1, 0); cyc("x0_write", 3'b001);
    end
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0); ret(0); mm_load_done = 1'b1; mm_load_rd = 0;
    cyc("x0_read", 3'b001);
    drv(1, 0, 0, 0, 0, 1, 1, 0, 1);          cyc("jal_issue", 3'b001);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("flush_1", 3'b010);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("flush_2", 3'b010);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0); ret(1);  cyc("flush_done", 3'b001);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);          cyc("jal2_issue", 3'b001);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 1'b1;
    cyc("redirect_flush", 3'b010);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("redirect_done", 3'b001);
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0);          cyc("wr_x9", 3'b001);
    drv(1, 9, 1, 0, 0, 0, 0, 0, 1);          cyc("jump_stalled", 3'b100);
    drv(1, 9, 1, 0, 0, 0, 0, 0, 1); ret(9);  cyc("jump_still_stalled", 3'b100);
    drv(1, 9, 1, 0, 0, 0, 0, 0, 1);          cyc("jump_issue", 3'b001);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("jump_flush_1", 3'b010);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("jump_flush_2", 3'b010);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);          cyc("jump_idle", 3'b000);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc("wr_x3", 3'b001);
    end
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);          cyc("max_stall", 3'b100);
    drv(1, 3, 0, 3, 0, 0, 0, 0, 0);          cyc("unused_src", 3'b001);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0); ret(3);  cyc("max_same_retire", 3'b100);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0); ret(3);  cyc("inc_dec_net", 3'b001);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);          cyc("refill_x3", 3'b001);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);          cyc("max_again", 3'b100);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0); ret(3); cyc("drain_x3", 3'b000);
    end
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);          cyc("wr_x4_a", 3'b001);
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);          cyc("wr_x4_b", 3'b001);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);          cyc("jal3_issue", 3'b001);
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0);
    #2 chk("flush_pre_reset", {stall, bubble, issue}, 3'b010);
    resetn = 1'b0;
    #1 chk("reset_mid", {stall, bubble, issue}, 3'b000);
    @(posedge clk); #1;
    #1 chk("reset_held", {stall, bubble, issue}, 3'b000);
    resetn = 1'b1;
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0);          cyc("x4_clear", 3'b001);
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0);          cyc("no_bubble", 3'b001);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
